// File: rtl/piezo_seq_ctrl_if.sv
// Note handshake between the piezo sequencer (master) and the tone generator (slave).
// note_start pulses one cycle with note_period/note_dur valid; they hold until the
// generator answers with a one-cycle note_done. tone_en is high while the note plays.
interface piezo_seq_ctrl_if;
    logic        note_start;
    logic [15:0] note_period;
    logic [24:0] note_dur;
    logic        tone_en;
    logic        note_done;

    modport master (
        output note_start,
        output note_period,
        output note_dur,
        output tone_en,
        input  note_done
    );

    modport slave (
        input  note_start,
        input  note_period,
        input  note_dur,
        input  tone_en,
        output note_done
    );
endinterface

// File: rtl/piezo_seq_ctrl.sv
// Piezo alert sequencer: fixed-priority arbitration of alert requests, note ROM walk
// per mode, one-note-at-a-time issue to the tone generator, and the repeat timer.
module piezo_seq_ctrl #(
    parameter bit          fast_sim   = 1'b1,
    parameter int unsigned rpt_cycles = fast_sim ? 2_343_750 : 150_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en_steer,
    input  logic                    i_too_fast,
    input  logic                    i_batt_low,
    piezo_seq_ctrl_if.master        bus,
    output logic [1:0]              o_mode,
    output logic [1:0]              o_state,
    output logic [2:0]              o_note_idx,
    output logic [27:0]             o_rpt_timer
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_WAIT_NOTE   = 2'd2,
        S_REPEAT_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_NONE  = 2'd0,
        M_STEER = 2'd1,
        M_BATT  = 2'd2,
        M_FAST  = 2'd3
    } mode_t;

    localparam logic [27:0] RPT_LAST = 28'(rpt_cycles - 1);

    state_t      r_state;
    mode_t       r_mode;
    logic [2:0]  r_idx;
    logic [27:0] r_timer;
    logic [15:0] r_period;
    logic [24:0] r_dur;

    state_t      w_nxt_state;
    mode_t       w_nxt_mode;
    mode_t       w_win;
    logic [2:0]  w_nxt_idx;
    logic [27:0] w_nxt_timer;
    logic        w_load;

    function automatic logic [15:0] rom_period(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'd31888;
            3'd1:    return 16'd23889;
            3'd2:    return 16'd18961;
            3'd3:    return 16'd15944;
            3'd4:    return 16'd18961;
            3'd5:    return 16'd15944;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [24:0] rom_dur(input logic [2:0] idx);
        logic [24:0] base;
        case (idx)
            3'd3:    base = 25'h0C0_0000;
            3'd4:    base = 25'h040_0000;
            3'd5:    base = 25'h100_0000;
            default: base = 25'h080_0000;
        endcase
        return fast_sim ? (base >> 6) : base;
    endfunction

    function automatic mode_t arbitrate(input logic fast, input logic batt, input logic steer);
        if (fast)       return M_FAST;
        else if (batt)  return M_BATT;
        else if (steer) return M_STEER;
        else            return M_NONE;
    endfunction

    // Battery alarm plays the fanfare backwards, so it starts at the top of the ROM.
    function automatic logic [2:0] first_idx(input mode_t m);
        return (m == M_BATT) ? 3'd5 : 3'd0;
    endfunction

    function automatic logic seq_last(input mode_t m, input logic [2:0] idx);
        case (m)
            M_STEER: return idx == 3'd5;
            M_BATT:  return idx == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] seq_next(input mode_t m, input logic [2:0] idx);
        case (m)
            M_FAST:  return (idx >= 3'd2) ? 3'd0 : idx + 3'd1;
            M_BATT:  return idx - 3'd1;
            default: return idx + 3'd1;
        endcase
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mode  = r_mode;
        w_nxt_idx   = r_idx;
        w_nxt_timer = r_timer;
        w_load      = 1'b0;
        w_win       = arbitrate(i_too_fast, i_batt_low, i_en_steer);

        case (r_state)
            S_IDLE: begin
                if (w_win != M_NONE) begin
                    w_nxt_state = S_ISSUE;
                    w_nxt_mode  = w_win;
                    w_nxt_idx   = first_idx(w_win);
                    w_load      = 1'b1;
                end
            end
            S_ISSUE: begin
                w_nxt_state = S_WAIT_NOTE;
            end
            S_WAIT_NOTE: begin
                if (bus.note_done) begin
                    if (w_win == M_NONE) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_mode  = M_NONE;
                    end else if (w_win != r_mode) begin
                        w_nxt_state = S_ISSUE;
                        w_nxt_mode  = w_win;
                        w_nxt_idx   = first_idx(w_win);
                        w_load      = 1'b1;
                    end else if (seq_last(r_mode, r_idx)) begin
                        w_nxt_state = S_REPEAT_WAIT;
                        w_nxt_timer = 28'd0;
                    end else begin
                        w_nxt_state = S_ISSUE;
                        w_nxt_idx   = seq_next(r_mode, r_idx);
                        w_load      = 1'b1;
                    end
                end
            end
            S_REPEAT_WAIT: begin
                // Any change of winner (higher request arriving or latched one dropping) ends the wait.
                if (w_win == M_NONE) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_mode  = M_NONE;
                    w_nxt_timer = 28'd0;
                end else if (w_win != r_mode) begin
                    w_nxt_state = S_ISSUE;
                    w_nxt_mode  = w_win;
                    w_nxt_idx   = first_idx(w_win);
                    w_nxt_timer = 28'd0;
                    w_load      = 1'b1;
                end else if (r_timer == RPT_LAST) begin
                    w_nxt_state = S_ISSUE;
                    w_nxt_idx   = first_idx(r_mode);
                    w_nxt_timer = 28'd0;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_timer = r_timer + 28'd1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_mode  = M_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= M_NONE;
            r_idx    <= 3'd0;
            r_timer  <= 28'd0;
            r_period <= 16'd0;
            r_dur    <= 25'd0;
        end else begin
            r_state <= w_nxt_state;
            r_mode  <= w_nxt_mode;
            r_idx   <= w_nxt_idx;
            r_timer <= w_nxt_timer;
            if (w_load) begin
                r_period <= rom_period(w_nxt_idx);
                r_dur    <= rom_dur(w_nxt_idx);
            end
        end
    end

    assign bus.note_start  = (r_state == S_ISSUE);
    assign bus.tone_en     = (r_state == S_WAIT_NOTE);
    assign bus.note_period = r_period;
    assign bus.note_dur    = r_dur;

    assign o_mode      = r_mode;
    assign o_state     = r_state;
    assign o_note_idx  = r_idx;
    assign o_rpt_timer = r_timer;

endmodule
